fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage with PC register, next-PC logic and IF/ID pipeline register.
//   Drives the byte address into the instruction memory (readAddress) and captures the
//   32-bit big-endian word it returns (Instruccion) one cycle later into IF/ID.
//   Handles stall, flush and branch redirect from downstream, and traps misaligned targets.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset; must be word-aligned and < IMEM_BYTES
//   IMEM_BYTES 256            instruction memory size in bytes; power of two, >= 8
//   NOP_INSTR  32'h0000_0000  word inserted into IF/ID on bubbles
// PORTS
//   clk           in   1   rising-edge clock
//   reset         in   1   asynchronous, active-high reset
//   stall         in   1   hold PC and IF/ID (hazard unit)
//   flush         in   1   replace IF/ID contents with a bubble
//   branch_taken  in   1   redirect PC to branch_target
//   branch_target in   32  byte address of redirect target
//   instr_in      in   32  word read from memory at pc_out (combinational)
//   pc_out        out  32  current PC; connects to memory readAddress
//   ifid_instr    out  32  registered instruction
//   ifid_pc4      out  32  registered PC+4 of that instruction
//   ifid_valid    out  1   1 = IF/ID holds a real instruction, 0 = bubble
//   misalign_err  out  1   sticky: a redirect target had bits[1:0] != 0
// BEHAVIOUR
//   Reset (async, any cycle): pc_out=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc4=0,
//     ifid_valid=0, misalign_err=0, state=BOOT. A fetch in progress is abandoned.
//   FSM states: BOOT, RUN, ERR.
//     BOOT: one cycle; PC holds, IF/ID gets a bubble, go to RUN (stall/flush/branch ignored).
//     RUN : normal fetch, rules below. Misaligned branch_target with branch_taken -> ERR.
//     ERR : PC frozen, IF/ID gets a bubble every cycle, misalign_err=1; exit only by reset.
//   Wrap rule: pc4 = (pc_out + 4) & (IMEM_BYTES-1); redirect PC = branch_target & (IMEM_BYTES-1).
//     PC is always word-aligned and <= IMEM_BYTES-4, so pc_out+3 never exceeds memory.
//   RUN priority per cycle, highest first:
//     1 branch_taken, target aligned: PC <= masked target; IF/ID <= bubble (overrides stall).
//     2 branch_taken, target misaligned: PC holds; IF/ID <= bubble; misalign_err<=1; ->ERR.
//     3 flush: PC <= pc4; IF/ID <= bubble (flush overrides stall).
//     4 stall: PC, ifid_instr, ifid_pc4, ifid_valid all hold.
//     5 otherwise: ifid_instr<=instr_in; ifid_pc4<=pc4; ifid_valid<=1; PC<=pc4.
//   Bubble = ifid_instr<=NOP_INSTR, ifid_pc4<=0, ifid_valid<=0.
//   Latency: word at address A appears on ifid_instr the cycle after pc_out==A (no stall).
//   ifid_pc4 of the instruction at IMEM_BYTES-4 is 0 (wrapped), not IMEM_BYTES.
//   All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//   Shared package: FSM state encoding (BOOT/RUN/ERR, 2 bits), NOP_INSTR, word size 4.
//   One sub-module: ifid_reg (IF/ID register with hold, bubble and async reset).
//   Next-PC mux and FSM stay in fetch_stage. Memory stays external.
// TESTING
//   Reset, then 4 free-run cycles with memory preloaded -> pc_out 0,0,4,8,12;
//     ifid_valid 0,0,1,1,1; ifid_pc4 0,0,4,8,12.
//   stall=1 for 3 cycles with pc_out=8 -> pc_out stays 8, IF/ID unchanged; release -> resumes at 12.
//   branch_taken=1 with target 0x40 while stall=1 -> next pc_out=0x40, ifid_valid=0; then 0x44.
//   Free-run from pc_out=252 (IMEM_BYTES=256) -> next pc_out=0, ifid_pc4=0, ifid_valid=1.
//   branch_taken=1 with target 0x22 -> misalign_err=1, pc_out frozen, ifid_valid=0 until reset.
//   Assert reset mid-stall at pc_out=0x30 -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared FSM encoding and constants for the instruction-fetch stage.
package fetch_stage_pkg;
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam int unsigned WORD_BYTES = 4;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// fetch_stage_ifid_reg: IF/ID pipeline register with hold, bubble insertion and async reset.
module fetch_stage_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);
  logic [31:0] instr_q, pc4_q;
  logic        valid_q;
  // A bubble wins over hold so redirects and flushes can squash a stalled slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and BOOT/RUN/ERR control feeding the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256,
  parameter logic [31:0] NOP_INSTR  = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        misalign_err
);
  localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc4;
  logic        err_q, err_d, run, br_bad, bubble;
  assign pc4    = (pc_q + 32'(WORD_BYTES)) & ADDR_MASK;
  assign br_bad = branch_taken && (branch_target[1:0] != 2'b00);
  assign run    = (state_q == ST_RUN);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = (state_q == ST_BOOT)    ? ST_RUN :
              (run && br_bad)         ? ST_ERR : state_q;
  end
  // Outside RUN the PC is frozen and IF/ID only ever receives bubbles.
  always_comb begin
    bubble = !run || branch_taken || flush;
    err_d  = err_q || (run && br_bad);
    pc_d   = (!run || br_bad)     ? pc_q :
             branch_taken         ? (branch_target & ADDR_MASK) :
             (flush || !stall)    ? pc4 : pc_q;
  end
  fetch_stage_ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (stall),
    .bubble_i (bubble),
    .instr_i  (instr_in),
    .pc4_i    (pc4),
    .instr_o  (ifid_instr),
    .pc4_o    (ifid_pc4),
    .valid_o  (ifid_valid)
  );
  assign pc_out       = pc_q;
  assign misalign_err = err_q;
endmodule
